// File: rtl/tc_program_fetch8_pkg.sv
// Shared definitions for the 8-bit program fetch unit: state encoding, widths and defaults.
// Imported by tc_program_fetch8.
package tc_program_fetch8_pkg;

  typedef enum logic {
    ST_FETCH = 1'b0,
    ST_HOLD  = 1'b1
  } fetch_state_e;

  localparam int DEFAULT_INSTR_BYTES = 4;
  localparam int INSTR_W             = 32;
  localparam int ADDR_W              = 16;
  localparam int CNT_W               = 3;

endpackage

// File: rtl/tc_program_fetch8.sv
// Program fetch initiator: walks the PC over an 8-bit registered ROM, assembles INSTR_BYTES bytes
// into one instruction word and hands it to the decoder with valid/ready back-pressure.
module tc_program_fetch8
  import tc_program_fetch8_pkg::*;
#(
  parameter int                INSTR_BYTES = DEFAULT_INSTR_BYTES,
  parameter logic [ADDR_W-1:0] RESET_PC    = 16'h0000
) (
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  address,
  input  logic [7:0]         rom_data,
  input  logic               jump_valid,
  input  logic [ADDR_W-1:0]  jump_target,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready
);

  localparam logic [ADDR_W-1:0] PC_STEP  = ADDR_W'(INSTR_BYTES);
  localparam logic [CNT_W-1:0]  N_CNT    = CNT_W'(INSTR_BYTES);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(INSTR_BYTES - 1);

  fetch_state_e       r_state;
  logic [ADDR_W-1:0]  r_address;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_instr_pc;
  logic [INSTR_W-1:0] r_instr;
  logic               r_valid;
  logic [CNT_W-1:0]   r_issue_cnt;
  logic [CNT_W-1:0]   r_recv_cnt;

  logic               w_issue;
  logic               w_recv;
  logic               w_last;
  logic [ADDR_W-1:0]  w_next_pc;

  // The ROM answers one edge after it samples the address, so receive trails issue by one.
  assign w_issue   = (r_issue_cnt < N_CNT);
  assign w_recv    = (r_recv_cnt < r_issue_cnt);
  assign w_last    = w_recv && (r_recv_cnt == LAST_CNT);
  assign w_next_pc = r_pc + PC_STEP;

  // NOTE: every register here is reset asynchronously and updated with non-blocking
  // assignments so all state moves together on the edge regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_FETCH;
      r_address   <= RESET_PC;
      r_pc        <= RESET_PC;
      r_instr_pc  <= '0;
      r_instr     <= '0;
      r_valid     <= 1'b0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else if (jump_valid) begin
      // Redirect wins over everything; the byte the ROM returns next edge is never captured
      // because the receive counter restarts behind a zero issue counter.
      r_state     <= ST_FETCH;
      r_address   <= jump_target;
      r_pc        <= jump_target;
      r_instr     <= '0;
      r_valid     <= 1'b0;
      r_issue_cnt <= '0;
      r_recv_cnt  <= '0;
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_issue) begin
            r_address   <= r_address + 16'd1;
            r_issue_cnt <= r_issue_cnt + 3'd1;
          end
          if (w_recv) begin
            r_instr[{r_recv_cnt[1:0], 3'b000} +: 8] <= rom_data;
            r_recv_cnt <= r_recv_cnt + 3'd1;
            if (w_last) begin
              r_valid    <= 1'b1;
              r_instr_pc <= r_pc;
              r_state    <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (instr_ready) begin
            r_state     <= ST_FETCH;
            r_address   <= w_next_pc;
            r_pc        <= w_next_pc;
            r_instr     <= '0;
            r_valid     <= 1'b0;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
          end
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign address     = r_address;
  assign instr       = r_instr;
  assign instr_pc    = r_instr_pc;
  assign instr_valid = r_valid;

endmodule

// File: tb/tb_tc_program_fetch8.sv
// Directed bench for tc_program_fetch8: two instances (RESET_PC 0 and FFFE) each driving a
// registered 64K x 8 ROM model; expected words are hand-computed from the ROM contents.
module tb_tc_program_fetch8;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: RESET_PC = 0
  logic        rst0, jump0, ready0, valid0;
  logic [15:0] addr0, tgt0, ipc0;
  logic [7:0]  rom0;
  logic [31:0] instr0;
  // Instance 1: RESET_PC = FFFE
  logic        rst1, jump1, ready1, valid1;
  logic [15:0] addr1, tgt1, ipc1;
  logic [7:0]  rom1;
  logic [31:0] instr1;

  logic [7:0]  mem0 [0:65535];
  logic [7:0]  mem1 [0:65535];

  int n_checks = 0;
  int n_errors = 0;
  int n_xfer0  = 0;

  tc_program_fetch8 #(.INSTR_BYTES(4), .RESET_PC(16'h0000)) u_dut0 (
    .clk(clk), .rst(rst0), .address(addr0), .rom_data(rom0),
    .jump_valid(jump0), .jump_target(tgt0), .instr(instr0), .instr_pc(ipc0),
    .instr_valid(valid0), .instr_ready(ready0)
  );

  tc_program_fetch8 #(.INSTR_BYTES(4), .RESET_PC(16'hFFFE)) u_dut1 (
    .clk(clk), .rst(rst1), .address(addr1), .rom_data(rom1),
    .jump_valid(jump1), .jump_target(tgt1), .instr(instr1), .instr_pc(ipc1),
    .instr_valid(valid1), .instr_ready(ready1)
  );

  // Registered ROM models: byte of the address sampled on the previous edge
  always @(posedge clk) begin
    rom0 <= mem0[addr0];
    rom1 <= mem1[addr1];
  end

  always @(posedge clk) begin
    if (!rst0 && valid0 && ready0) n_xfer0 <= n_xfer0 + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%h expected=%h", tag, act, exp);
    end
  endtask

  // Five edges from the start of FETCH: valid only on the fifth, then the word and its PC
  task automatic expect_instr0(input string tag, input logic [15:0] pc, input logic [31:0] word);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check({tag, "_valid"}, {31'd0, valid0}, {31'd0, (i == 5)});
    end
    check({tag, "_pc"}, {16'd0, ipc0}, {16'd0, pc});
    check({tag, "_instr"}, instr0, word);
  endtask

  task automatic check_reset0(input string tag);
    check({tag, "_addr"}, {16'd0, addr0}, 32'h0000_0000);
    check({tag, "_instr"}, instr0, 32'h0000_0000);
    check({tag, "_pc"}, {16'd0, ipc0}, 32'h0000_0000);
    check({tag, "_valid"}, {31'd0, valid0}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int xb;
    bit found;

    for (int i = 0; i < 65536; i++) begin
      mem0[i] = 8'(i) + 8'h80;
      mem1[i] = 8'(i) + 8'h80;
    end
    {mem0[0], mem0[1], mem0[2], mem0[3]}             = {8'h11, 8'h22, 8'h33, 8'h44};
    {mem0[4], mem0[5], mem0[6], mem0[7]}             = {8'h55, 8'h66, 8'h77, 8'h88};
    {mem0[8], mem0[9], mem0[10], mem0[11]}           = {8'h99, 8'hAA, 8'hBB, 8'hCC};
    {mem0[16], mem0[17], mem0[18], mem0[19]}         = {8'hDE, 8'hAD, 8'hBE, 8'hEF};
    {mem0[32], mem0[33], mem0[34], mem0[35]}         = {8'h01, 8'h02, 8'h03, 8'h04};
    {mem1[65534], mem1[65535], mem1[0], mem1[1]}     = {8'hA1, 8'hB2, 8'hC3, 8'hD4};

    rst0 = 1'b1; rst1 = 1'b1;
    jump0 = 1'b0; tgt0 = 16'h0000; ready0 = 1'b1;
    jump1 = 1'b0; tgt1 = 16'h0000; ready1 = 1'b1;
    repeat (2) tick();
    check_reset0("rst");
    check("rst1_addr", {16'd0, addr1}, 32'h0000_FFFE);
    check("rst1_valid", {31'd0, valid1}, 32'd0);

    // 1: first instruction from PC 0, valid for exactly one cycle with ready high
    rst0 = 1'b0;
    expect_instr0("t1", 16'h0000, 32'h4433_2211);
    tick();
    check("t1_once", {31'd0, valid0}, 32'd0);
    check("t1_addr", {16'd0, addr0}, 32'h0000_0004);
    check("t1_xfer", n_xfer0, 1);

    // 2: back-pressure for 10 cycles, everything held stable
    ready0 = 1'b0;
    expect_instr0("t2", 16'h0004, 32'h8877_6655);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("t2_hold_valid", {31'd0, valid0}, 32'd1);
      check("t2_hold_instr", instr0, 32'h8877_6655);
      check("t2_hold_pc", {16'd0, ipc0}, 32'h0000_0004);
      check("t2_hold_addr", {16'd0, addr0}, 32'h0000_0008);
    end
    ready0 = 1'b1;
    tick();
    check("t2_release", {31'd0, valid0}, 32'd0);
    check("t2_xfer", n_xfer0, 2);

    // 3: jump after two bytes of the PC-8 instruction have been collected
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t3_pre_valid", {31'd0, valid0}, 32'd0);
    end
    jump0 = 1'b1; tgt0 = 16'h0010;
    tick();
    jump0 = 1'b0;
    check("t3_jmp_valid", {31'd0, valid0}, 32'd0);
    check("t3_jmp_addr", {16'd0, addr0}, 32'h0000_0010);
    expect_instr0("t3", 16'h0010, 32'hEFBE_ADDE);

    // 6: jump and transfer on the same edge
    tick();
    check("t6_gap", {31'd0, valid0}, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (valid0) found = 1'b1;
    end
    check("t6_wait", {31'd0, found}, 32'd1);
    check("t6_pre_pc", {16'd0, ipc0}, 32'h0000_0014);
    check("t6_pre_instr", instr0, 32'h9796_9594);
    xb = n_xfer0;
    jump0 = 1'b1; tgt0 = 16'h0020;
    tick();
    jump0 = 1'b0;
    check("t6_xfer", n_xfer0 - xb, 1);
    check("t6_valid", {31'd0, valid0}, 32'd0);
    check("t6_addr", {16'd0, addr0}, 32'h0000_0020);
    expect_instr0("t6", 16'h0020, 32'h0403_0201);

    // 5a: reset mid-FETCH (one byte already captured)
    repeat (3) tick();
    rst0 = 1'b1;
    #1;
    check_reset0("t5_fetch_rst");
    tick();
    rst0 = 1'b0;
    expect_instr0("t5a", 16'h0000, 32'h4433_2211);

    // 5b: reset mid-HOLD
    ready0 = 1'b0;
    tick();
    check("t5_hold_valid", {31'd0, valid0}, 32'd1);
    rst0 = 1'b1;
    #1;
    check_reset0("t5_hold_rst");
    tick();
    rst0 = 1'b0;
    ready0 = 1'b1;
    expect_instr0("t5b", 16'h0000, 32'h4433_2211);

    // 4: RESET_PC near the top of memory, address wraps mid-instruction
    rst1 = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("t4_valid", {31'd0, valid1}, {31'd0, (i == 5)});
    end
    check("t4_instr", instr1, 32'hD4C3_B2A1);
    check("t4_pc", {16'd0, ipc1}, 32'h0000_FFFE);
    tick();
    check("t4_release", {31'd0, valid1}, 32'd0);
    check("t4_addr", {16'd0, addr1}, 32'h0000_0002);
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("t4b_valid", {31'd0, valid1}, {31'd0, (i == 5)});
    end
    check("t4b_pc", {16'd0, ipc1}, 32'h0000_0002);
    check("t4b_instr", instr1, 32'h8584_8382);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
